// File: rtl/float_pkg.sv
// Shared definitions for the compressed float format (sign, exponent, significand)
// and the linear expansion used by the decoder, the encoder and their benches.
package float_pkg;

  localparam int EXP_W   = 3;
  localparam int SIG_W   = 4;
  // Wide enough for F shifted by the largest exponent, plus a sign bit.
  localparam int OUT_W   = 12;
  localparam int MAX_MAG = 1920;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [SIG_W-1:0] significand;
  } float_word_t;

endpackage

// File: rtl/float_decoder_if.sv
// Input word and output result handshakes of the float decoder.
interface float_decoder_if;
  import float_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [EXP_W-1:0] exponent;
  logic [SIG_W-1:0] significand;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] D;

  modport master (
    output in_valid, sign, exponent, significand, out_ready,
    input  in_ready, out_valid, D
  );

  modport slave (
    input  in_valid, sign, exponent, significand, out_ready,
    output in_ready, out_valid, D
  );

endinterface

// File: rtl/float_decoder.sv
// Expands a compressed float word to a two's-complement linear value by shifting
// the significand left once per exponent count, then applying the sign.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | acc shifted left while cnt counts down to zero
// FIX   | sign applied, result registered into D
// DONE  | result held with out_valid until out_ready
module float_decoder
  import float_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  float_decoder_if.slave bus
);

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [EXP_W-1:0] cnt;
  logic             sign_q;
  logic [OUT_W-1:0] d_q;
  float_word_t      word;

  assign word          = '{sign: bus.sign, exponent: bus.exponent, significand: bus.significand};
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.D         = d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      d_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc    <= {{(OUT_W-SIG_W){1'b0}}, word.significand};
            cnt    <= word.exponent;
            sign_q <= word.sign;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            acc <= acc << 1;
            cnt <= cnt - EXP_W'(1);
          end
        end
        FIX: begin
          // Negating zero yields zero, so a negative-zero word decodes to 0.
          d_q   <= sign_q ? -acc : acc;
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_decoder.sv
// Directed bench for float_decoder: scoreboard of expected results and
// accept cycles, checked by a monitor whenever out_valid is seen.
module tb_float_decoder;
  import float_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [OUT_W-1:0] d;
    int               e;
    int               acc_cyc;
  } exp_t;

  exp_t q[$];
  logic prev_valid = 1'b0;

  float_decoder_if bus_if ();

  float_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives a word from the posedge+1 phase, waits for acceptance, records the model result.
  task automatic send(input logic s, input int e, input int f, output int acc_cyc);
    int   n;
    int   v;
    exp_t x;
    n = 0;
    bus_if.in_valid    = 1'b1;
    bus_if.sign        = s;
    bus_if.exponent    = 3'(e);
    bus_if.significand = 4'(f);
    while (!bus_if.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept", {31'd0, bus_if.in_ready}, 32'd1);
    v         = f * (1 << e);
    if (s) v  = -v;
    x.d       = v[OUT_W-1:0];
    x.e       = e;
    x.acc_cyc = cyc + 1;
    acc_cyc   = x.acc_cyc;
    q.push_back(x);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus_if.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_wait", {31'd0, bus_if.out_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus_if.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) chk("latency", cyc - q[0].acc_cyc, q[0].e + 2);
          chk("d", {20'd0, bus_if.D}, {20'd0, q[0].d});
          if (bus_if.out_ready) void'(q.pop_front());
        end
      end
      prev_valid = bus_if.out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int last_a;
    int last_e;
    bit first;

    bus_if.in_valid    = 1'b0;
    bus_if.sign        = 1'b0;
    bus_if.exponent    = '0;
    bus_if.significand = '0;
    bus_if.out_ready   = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst_d", {20'd0, bus_if.D}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);

    // Zero word, minimum latency, in_ready back right after the handshake.
    send(1'b0, 0, 0, a);
    wait_valid();
    chk("zero_d", {20'd0, bus_if.D}, 32'h000);
    @(posedge clk); #1;
    chk("ready_after_hs", {31'd0, bus_if.in_ready}, 32'd1);
    chk("valid_after_hs", {31'd0, bus_if.out_valid}, 32'd0);

    // Largest magnitude.
    send(1'b0, 7, 15, a);
    wait_valid();
    chk("max_d", {20'd0, bus_if.D}, 32'h780);
    @(posedge clk); #1;

    // Negative values and negative zero.
    send(1'b1, 2, 5, a);
    wait_valid();
    chk("neg20_d", {20'd0, bus_if.D}, 32'hFEC);
    @(posedge clk); #1;
    send(1'b1, 0, 0, a);
    wait_valid();
    chk("negzero_d", {20'd0, bus_if.D}, 32'h000);
    @(posedge clk); #1;

    // Backpressure with a second word waiting at the input.
    bus_if.out_ready = 1'b0;
    send(1'b0, 3, 9, a);
    wait_valid();
    bus_if.in_valid    = 1'b1;
    bus_if.sign        = 1'b1;
    bus_if.exponent    = 3'd1;
    bus_if.significand = 4'd3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
      chk("bp_d", {20'd0, bus_if.D}, 32'h048);
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    send(1'b1, 1, 3, a);
    wait_valid();
    chk("bp_second_d", {20'd0, bus_if.D}, 32'hFFA);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a long shift.
    send(1'b0, 6, 11, a);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("mid_rst_d", {20'd0, bus_if.D}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b1, 4, 7, a);
    wait_valid();
    chk("after_rst_d", {20'd0, bus_if.D}, 32'hF90);
    @(posedge clk); #1;

    // All 256 words back to back, checking the accept spacing.
    first = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < 8; e++) begin
        for (int f = 0; f < 16; f++) begin
          send(s[0], e, f, a);
          if (!first) chk("spacing", a - last_a, last_e + 4);
          first  = 1'b0;
          last_a = a;
          last_e = e;
        end
      end
    end

    for (int n = 0; n < 50 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
